// File: rtl/wave_gen_multi_if.sv
// ----------------------------------------------------------------------------
// wave_gen_multi_if
//   Control and sample bundle for the multi-mode waveform generator.
//   Optional feature macro: WAVE_GEN_AMP_LIMIT_EN (adds the amp signal).
//
//   Signals
//     en      advance enable (low = hold everything, flags forced 0)
//     mode    00 triangle, 01 saw-up, 10 saw-down, 11 square
//     step    increment per enabled cycle in the ramp modes
//     amp     (WAVE_GEN_AMP_LIMIT_EN only) run-time full-scale value
//     wave    registered waveform code
//     peak    one-cycle pulse when wave becomes full scale
//     trough  one-cycle pulse when wave becomes 0
//
//   Modports
//     master  drives the controls, receives the samples
//     slave   the generator itself
// ----------------------------------------------------------------------------
interface wave_gen_multi_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] step;
`ifdef WAVE_GEN_AMP_LIMIT_EN
    logic [WIDTH-1:0] amp;
`endif
    logic [WIDTH-1:0] wave;
    logic             peak;
    logic             trough;

    modport master (
        output en,
        output mode,
        output step,
`ifdef WAVE_GEN_AMP_LIMIT_EN
        output amp,
`endif
        input  wave,
        input  peak,
        input  trough
    );

    modport slave (
        input  en,
        input  mode,
        input  step,
`ifdef WAVE_GEN_AMP_LIMIT_EN
        input  amp,
`endif
        output wave,
        output peak,
        output trough
    );
endinterface

// File: rtl/wave_gen_multi.sv
// ----------------------------------------------------------------------------
// wave_gen_multi
//   Multi-mode waveform generator: triangle, sawtooth-up, sawtooth-down and
//   square codes, one sample per enabled clock, with peak/trough pulses
//   registered alongside the sample.
//   Optional feature macro: WAVE_GEN_AMP_LIMIT_EN -- full scale comes from
//   bus.amp (sampled every cycle) instead of the constant 2**WIDTH-1.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    wave_gen_multi_if.slave (en, mode, step, [amp], wave, peak, trough)
//
//   Parameters
//     WIDTH    output code width
//     SQ_HALF  square mode: enabled cycles per half-period (>= 1)
// ----------------------------------------------------------------------------
module wave_gen_multi #(
    parameter int WIDTH   = 5,
    parameter int SQ_HALF = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    wave_gen_multi_if.slave   bus
);

    localparam int            CW      = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
    localparam logic [CW-1:0] SQ_LAST = CW'(SQ_HALF - 1);

    localparam logic [1:0] MODE_TRI    = 2'b00;
    localparam logic [1:0] MODE_SAW_UP = 2'b01;
    localparam logic [1:0] MODE_SAW_DN = 2'b10;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    dir_t             dir_q, dir_d;
    logic [WIDTH-1:0] wave_q, wave_d;
    logic             peak_q, peak_d;
    logic             trough_q, trough_d;
    logic [CW-1:0]    sq_cnt_q, sq_cnt_d;
    logic [1:0]       mode_q, mode_d;

    logic [WIDTH-1:0] top;
    logic [WIDTH:0]   top_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             step_zero;
    logic             at_floor;

`ifdef WAVE_GEN_AMP_LIMIT_EN
    assign top = bus.amp;
`else
    assign top = {WIDTH{1'b1}};
`endif

    // Sum is kept one bit wider so a ramp past full scale saturates instead
    // of wrapping; diff is only used when wave is strictly above step.
    assign top_ext   = {1'b0, top};
    assign sum       = {1'b0, wave_q} + {1'b0, bus.step};
    assign diff      = wave_q - bus.step;
    assign step_zero = (bus.step == '0);
    assign at_floor  = (wave_q <= bus.step);

    // State register: everything the generator remembers between samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q    <= DIR_UP;
            wave_q   <= '0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            sq_cnt_q <= '0;
            mode_q   <= MODE_TRI;
        end else begin
            dir_q    <= dir_d;
            wave_q   <= wave_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            sq_cnt_q <= sq_cnt_d;
            mode_q   <= mode_d;
        end
    end

    // Next-sample logic. With en low everything holds and the flags drop.
    // A mode change restarts the new waveform from 0 (reported as a trough).
    always_comb begin
        dir_d    = dir_q;
        wave_d   = wave_q;
        peak_d   = 1'b0;
        trough_d = 1'b0;
        sq_cnt_d = sq_cnt_q;
        mode_d   = mode_q;

        if (bus.en) begin
            if (bus.mode != mode_q) begin
                mode_d   = bus.mode;
                wave_d   = '0;
                dir_d    = DIR_UP;
                sq_cnt_d = '0;
                trough_d = 1'b1;
            end
`ifdef WAVE_GEN_AMP_LIMIT_EN
            // Zero amplitude pins the output at 0; a lowered amplitude pulls
            // the output straight down to the new full scale.
            else if (top == '0) begin
                wave_d   = '0;
                dir_d    = DIR_UP;
                trough_d = (wave_q != '0);
            end else if (wave_q > top) begin
                wave_d = top;
                peak_d = 1'b1;
                if (mode_q == MODE_TRI) begin
                    dir_d = DIR_DOWN;
                end
            end
`endif
            else begin
                case (mode_q)
                    MODE_TRI: begin
                        if (!step_zero) begin
                            if (dir_q == DIR_UP) begin
                                if (sum >= top_ext) begin
                                    wave_d = top;
                                    dir_d  = DIR_DOWN;
                                    peak_d = 1'b1;
                                end else begin
                                    wave_d = sum[WIDTH-1:0];
                                end
                            end else begin
                                if (at_floor) begin
                                    wave_d   = '0;
                                    dir_d    = DIR_UP;
                                    trough_d = 1'b1;
                                end else begin
                                    wave_d = diff;
                                end
                            end
                        end
                    end
                    MODE_SAW_UP: begin
                        if (!step_zero) begin
                            if (wave_q == top) begin
                                wave_d   = '0;
                                trough_d = 1'b1;
                            end else if (sum >= top_ext) begin
                                wave_d = top;
                                peak_d = 1'b1;
                            end else begin
                                wave_d = sum[WIDTH-1:0];
                            end
                        end
                    end
                    MODE_SAW_DN: begin
                        if (!step_zero) begin
                            if (wave_q == '0) begin
                                wave_d = top;
                                peak_d = 1'b1;
                            end else if (at_floor) begin
                                wave_d   = '0;
                                trough_d = 1'b1;
                            end else begin
                                wave_d = diff;
                            end
                        end
                    end
                    default: begin
                        // Square: step is ignored, level flips every SQ_HALF cycles.
                        if (sq_cnt_q == SQ_LAST) begin
                            sq_cnt_d = '0;
                            if (wave_q == '0) begin
                                wave_d = top;
                                peak_d = 1'b1;
                            end else begin
                                wave_d   = '0;
                                trough_d = 1'b1;
                            end
                        end else begin
                            sq_cnt_d = sq_cnt_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.wave   = wave_q;
    assign bus.peak   = peak_q;
    assign bus.trough = trough_q;

endmodule
